mul_seq: RTL
============

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 The block SHALL use parameter/macro `datawidth, default 32, as the operand width W taken from the shared defines file.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, the request to begin a multiply, sampled only in IDLE.
REQ-005 The block SHALL have port is_signed, input, 1 bit, selecting two's-complement (1) or unsigned (0) operands, sampled with start.
REQ-006 The block SHALL have ports data_A and data_B, input, W bits each, the multiplicand and multiplier, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit, high while in CALC, NEG_LO or NEG_HI.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse high only in state DONE.
REQ-009 The block SHALL have ports result_hi and result_lo, output, W bits each, the upper and lower halves of the 2W-bit product.
REQ-010 The block SHALL have port ovf, output, 1 bit, set when the product does not fit in W bits.

Function
REQ-011 The block SHALL instantiate exactly one existing adder module (W-bit, carry-in ci, carry-out co) and perform every product addition and final negation through it.
REQ-012 The FSM SHALL have states IDLE, CALC, NEG_LO, NEG_HI and DONE.
REQ-013 IDLE with start=1 at edge k: capture operands, go to CALC, clear iteration counter (5 bits for W=32, log2 W in general) and accumulator hi to 0.
REQ-014 Capture: signed mode stores |data_A|, |data_B| (two's-complement negate if MSB=1) and neg_flag = A[W-1] XOR B[W-1]; unsigned mode stores raw operands and neg_flag=0.
REQ-015 |0x80000000| SHALL be held as unsigned 0x80000000 (no saturation).
REQ-016 CALC, one iteration per edge: if lo[0]=1 then {co,sum}=hi+mcand and {hi,lo} <= {co,sum,lo}>>1, else {hi,lo} <= {0,hi,lo}>>1.
REQ-017 CALC SHALL run exactly W iterations (edges k+1..k+W), then go to NEG_LO if neg_flag=1 else DONE.
REQ-018 NEG_LO: adder computes ~lo+1; store sum in lo, register co as carry into NEG_HI.
REQ-019 NEG_HI: adder computes ~hi + carry; store sum in hi; go to DONE.
REQ-020 Latency: DONE entered at edge k+W (no negation) or k+W+2 (negation); done high for that one cycle; next edge returns to IDLE.
REQ-021 result_hi/result_lo SHALL be valid in DONE and hold their value in IDLE until the next accepted start.
REQ-022 ovf: unsigned, result_hi != 0; signed, result_hi != W copies of result_lo[W-1]; registered on entry to DONE, held with the results.
REQ-023 start while busy=1 or in DONE SHALL be ignored; no queuing.
REQ-024 Zero product with neg_flag=1 SHALL yield hi=lo=0 (carry out of NEG_LO propagates into NEG_HI).
REQ-025 Operand inputs changing after capture SHALL NOT affect the running operation.

Reset
REQ-026 rst_n=0 at any edge SHALL force IDLE, busy=0, done=0, ovf=0, result_hi=result_lo=0, counter=0, neg_flag=0.
REQ-027 Reset during CALC/NEG/DONE SHALL abort the operation; no done pulse follows.
REQ-028 start sampled with rst_n=0 SHALL be ignored.

Verification
REQ-029 Unsigned 3 x 5, start at edge k -> done high after edge k+32 only, result_hi=0, result_lo=0x0000000F, ovf=0.
REQ-030 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, ovf=1, done after edge k+32.
REQ-031 Signed -3 x 5 -> done after edge k+34, result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1, ovf=0.
REQ-032 Signed 0x80000000 x 0x80000000 -> result_hi=0x40000000, result_lo=0, ovf=1; signed -7 x 0 -> 0/0, ovf=0, done after edge k+34.
REQ-033 start pulsed at iteration 10 -> ignored, original result unchanged; rst_n=0 at iteration 10 -> next cycle busy=0, outputs 0, no done pulse.

Source files
------------

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: W iterations through a single shared adder, optional
// two's-complement fix-up of the magnitude product, and a registered 2W-bit result with overflow.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

module mul_seq_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

module mul_seq #(
  parameter int W = `DATAWIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] data_A,
  input  logic [W-1:0] data_B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result_hi,
  output logic [W-1:0] result_lo,
  output logic         ovf
);
  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_NEG_LO = 3'd2,
    S_NEG_HI = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic [W-1:0]   r_mcand;
  logic           r_neg;
  logic           r_signed;
  logic           r_carry;
  logic [W-1:0]   r_res_hi;
  logic [W-1:0]   r_res_lo;
  logic           r_ovf;

  logic [W-1:0]   w_add_a;
  logic [W-1:0]   w_add_b;
  logic           w_add_ci;
  logic [W-1:0]   w_sum;
  logic           w_co;
  logic [W-1:0]   w_hi_nxt;
  logic [W-1:0]   w_lo_nxt;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic           w_last;

  // Overflow: the upper half must be pure sign (or zero) extension of the lower half.
  function automatic logic ovf_of(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic sgn);
    logic [W-1:0] ext;
    ext = sgn ? {W{lo[W-1]}} : {W{1'b0}};
    return (hi != ext);
  endfunction

  mul_seq_adder #(.W(W)) u_adder (
    .a   (w_add_a),
    .b   (w_add_b),
    .ci  (w_add_ci),
    .sum (w_sum),
    .co  (w_co)
  );

  // Magnitude 0x80..0 negates to itself and is then treated as unsigned.
  assign w_abs_a = (is_signed && data_A[W-1]) ? (~data_A + {{(W-1){1'b0}}, 1'b1}) : data_A;
  assign w_abs_b = (is_signed && data_B[W-1]) ? (~data_B + {{(W-1){1'b0}}, 1'b1}) : data_B;
  assign w_last  = (r_cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_CALC : S_IDLE;
      S_CALC:   w_next = w_last ? (r_neg ? S_NEG_LO : S_DONE) : S_CALC;
      S_NEG_LO: w_next = S_NEG_HI;
      S_NEG_HI: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_CALC, S_NEG_LO, S_NEG_HI: busy = 1'b1;
      S_DONE:                     done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Adder operand steering and next accumulator value.
  always_comb begin
    w_add_a  = r_hi;
    w_add_b  = {W{1'b0}};
    w_add_ci = 1'b0;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    case (r_state)
      S_CALC: begin
        w_add_b = r_mcand;
        if (r_lo[0]) begin
          w_hi_nxt = {w_co, w_sum[W-1:1]};
          w_lo_nxt = {w_sum[0], r_lo[W-1:1]};
        end else begin
          w_hi_nxt = {1'b0, r_hi[W-1:1]};
          w_lo_nxt = {r_hi[0], r_lo[W-1:1]};
        end
      end
      S_NEG_LO: begin
        w_add_a  = ~r_lo;
        w_add_ci = 1'b1;
        w_lo_nxt = w_sum;
      end
      S_NEG_HI: begin
        w_add_a  = ~r_hi;
        w_add_ci = r_carry;
        w_hi_nxt = w_sum;
      end
      default: begin
        w_add_a  = r_hi;
        w_add_ci = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= {CW{1'b0}};
      r_hi     <= {W{1'b0}};
      r_lo     <= {W{1'b0}};
      r_mcand  <= {W{1'b0}};
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= w_abs_a;
            r_lo     <= w_abs_b;
            r_hi     <= {W{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_neg    <= is_signed & (data_A[W-1] ^ data_B[W-1]);
            r_signed <= is_signed;
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        S_NEG_LO: begin
          r_lo    <= w_sum;
          r_carry <= w_co;
        end
        S_NEG_HI: r_hi <= w_sum;
        default:  r_carry <= r_carry;
      endcase
    end
  end

  // Results and overflow are latched only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_hi <= {W{1'b0}};
      r_res_lo <= {W{1'b0}};
      r_ovf    <= 1'b0;
    end else if (w_next == S_DONE && r_state != S_DONE) begin
      r_res_hi <= w_hi_nxt;
      r_res_lo <= w_lo_nxt;
      r_ovf    <= ovf_of(w_hi_nxt, w_lo_nxt, r_signed);
    end else begin
      r_res_hi <= r_res_hi;
    end
  end

  assign result_hi = r_res_hi;
  assign result_lo = r_res_lo;
  assign ovf       = r_ovf;
endmodule
